// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator result path and UART framing.
// UART_TX_TERM_EN adds the TERM state used for the frame terminator byte.
package calc_pkg;

    localparam int unsigned DIGITS  = 4;
    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned BYTE_W  = 8;

    localparam logic [BYTE_W-1:0] ASCII_ZERO  = 8'h30;
    localparam logic [BYTE_W-1:0] ASCII_MINUS = 8'h2D;
    localparam logic [BYTE_W-1:0] ASCII_QMARK = 8'h3F;
    localparam logic [BYTE_W-1:0] ASCII_CR    = 8'h0D;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SIGN  = 2'd1,
        ST_DIGIT = 2'd2
`ifdef UART_TX_TERM_EN
        ,
        ST_TERM  = 2'd3
`endif
    } tx_seq_state_t;

    // digits[3] is the most significant digit (num1), digits[0] the least (num4)
    typedef struct packed {
        logic [CNT_W-1:0]                n;
        logic [DIGITS-1:0][DIGIT_W-1:0] digits;
        logic                            sign;
    } result_frame_t;

    // Digit counts above 4 are treated as 4
    function automatic logic [CNT_W-1:0] clamp_n(input logic [3:0] n_raw);
        return (n_raw > 4'd4) ? CNT_W'(4) : n_raw[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/tx_frame_slot.sv
// Snapshot register holding one result frame plus a valid flag.
// Load wins over clear so a slot can be refilled on the edge it is drained.
module tx_frame_slot
    import calc_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          load_i,
    input  logic          clear_i,
    input  result_frame_t frame_i,
    output result_frame_t frame_o,
    output logic          valid_o,
    output logic          valid_nxt_c_o
);

    result_frame_t frame_q, frame_d;
    logic          valid_q, valid_d;

    // Next snapshot and occupancy
    always_comb begin
        frame_d = frame_q;
        valid_d = valid_q;
        if (load_i) begin
            frame_d = frame_i;
            valid_d = 1'b1;
        end else if (clear_i) begin
            valid_d = 1'b0;
        end
    end

    // Snapshot register
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_q <= '0;
            valid_q <= 1'b0;
        end else begin
            frame_q <= frame_d;
            valid_q <= valid_d;
        end
    end

    assign frame_o       = frame_q;
    assign valid_o       = valid_q;
    assign valid_nxt_c_o = reset ? 1'b0 : valid_d;

endmodule

// File: rtl/uart_tx_sequencer.sv
// Streams a snapshotted calculator result as ASCII bytes over a valid/ready link,
// with one pending request slot. UART_TX_TERM_EN appends a terminator byte.
module uart_tx_sequencer
    import calc_pkg::*;
#(
    parameter logic [7:0] MINUS_BYTE = ASCII_MINUS,
    parameter logic [7:0] BAD_BYTE   = ASCII_QMARK
`ifdef UART_TX_TERM_EN
    ,
    parameter logic [7:0] TERM_BYTE  = ASCII_CR
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        n,
    input  logic [3:0]        num1,
    input  logic [3:0]        num2,
    input  logic [3:0]        num3,
    input  logic [3:0]        num4,
    input  logic              sign,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              overrun
);

    tx_seq_state_t      state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [BYTE_W-1:0]  tx_data_q, tx_data_d;
    logic               tx_valid_q, tx_valid_d;
    logic               busy_q, overrun_q, overrun_d;

    result_frame_t snap_frame, launch_frame, act_frame, pend_frame;
    logic          act_valid, act_nxt, act_load, act_clear;
    logic          pend_valid, pend_nxt, pend_load, pend_clear;
    logic          accept, launch;

    // ASCII byte for digit position idx of frame f; an empty frame reads as '0'
    function automatic logic [BYTE_W-1:0] digit_byte(input result_frame_t f,
                                                     input logic [IDX_W-1:0] idx);
        logic [DIGIT_W-1:0] d;
        d = f.digits[idx];
        if (f.n == '0)
            return ASCII_ZERO;
        else if (d > DIGIT_W'(9))
            return BAD_BYTE;
        else
            return ASCII_ZERO + BYTE_W'(d);
    endfunction

    // Index of the most significant transmitted digit
    function automatic logic [IDX_W-1:0] first_idx(input result_frame_t f);
        return (f.n == '0) ? '0 : IDX_W'(f.n - CNT_W'(1));
    endfunction

    assign snap_frame   = '{n: clamp_n(n), digits: {num1, num2, num3, num4}, sign: sign};
    assign accept       = tx_valid_q && tx_ready;
    // The pending frame is promoted to active on the IDLE reload edge
    assign launch       = (state_q == ST_IDLE) && (pend_valid || start);
    assign launch_frame = pend_valid ? pend_frame : snap_frame;

    tx_frame_slot u_active (
        .clk           (clk),
        .reset         (reset),
        .load_i        (act_load),
        .clear_i       (act_clear),
        .frame_i       (launch_frame),
        .frame_o       (act_frame),
        .valid_o       (act_valid),
        .valid_nxt_c_o (act_nxt)
    );

    tx_frame_slot u_pending (
        .clk           (clk),
        .reset         (reset),
        .load_i        (pend_load),
        .clear_i       (pend_clear),
        .frame_i       (snap_frame),
        .frame_o       (pend_frame),
        .valid_o       (pend_valid),
        .valid_nxt_c_o (pend_nxt)
    );

    // Pending slot admission and overrun detection
    always_comb begin
        pend_load  = 1'b0;
        pend_clear = 1'b0;
        overrun_d  = 1'b0;
        if (state_q == ST_IDLE && pend_valid)
            pend_clear = 1'b1;
        if (start) begin
            if (act_valid) begin
                pend_load = !pend_valid;
                overrun_d = pend_valid;
            end else begin
                pend_load = pend_valid;
            end
        end
    end

    // Next-state and byte generation
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        act_load   = 1'b0;
        act_clear  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_valid_d = 1'b0;
                if (launch) begin
                    act_load   = 1'b1;
                    idx_d      = first_idx(launch_frame);
                    tx_valid_d = 1'b1;
                    if (launch_frame.sign) begin
                        state_d   = ST_SIGN;
                        tx_data_d = MINUS_BYTE;
                    end else begin
                        state_d   = ST_DIGIT;
                        tx_data_d = digit_byte(launch_frame, first_idx(launch_frame));
                    end
                end
            end
            ST_SIGN: begin
                if (accept) begin
                    state_d   = ST_DIGIT;
                    tx_data_d = digit_byte(act_frame, idx_q);
                end
            end
            ST_DIGIT: begin
                if (accept) begin
                    if (idx_q == '0) begin
`ifdef UART_TX_TERM_EN
                        state_d   = ST_TERM;
                        tx_data_d = TERM_BYTE;
`else
                        state_d    = ST_IDLE;
                        tx_valid_d = 1'b0;
                        act_clear  = 1'b1;
`endif
                    end else begin
                        idx_d     = idx_q - IDX_W'(1);
                        tx_data_d = digit_byte(act_frame, idx_q - IDX_W'(1));
                    end
                end
            end
`ifdef UART_TX_TERM_EN
            ST_TERM: begin
                if (accept) begin
                    state_d    = ST_IDLE;
                    tx_valid_d = 1'b0;
                    act_clear  = 1'b1;
                end
            end
`endif
            default: begin
                state_d    = ST_IDLE;
                tx_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= act_nxt || pend_nxt;
            overrun_q  <= overrun_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Directed bench for uart_tx_sequencer with a byte scoreboard.
// Honours UART_TX_TERM_EN when computing expected frames.
module tb_uart_tx_sequencer;

    logic       clk = 1'b0;
    logic       reset, start, sign, tx_ready;
    logic [3:0] n, num1, num2, num3, num4;
    logic [7:0] tx_data;
    logic       tx_valid, busy, overrun;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_tx_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .n        (n),
        .num1     (num1),
        .num2     (num2),
        .num3     (num3),
        .num4     (num4),
        .sign     (sign),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy),
        .overrun  (overrun)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every transfer must match the oldest expected byte
    always @(negedge clk) begin
        if (reset === 1'b0 && tx_valid === 1'b1 && tx_ready === 1'b1) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_byte observed=%h expected=none", tx_data);
            end
            if (exp_q.size() > 0) check("tx_byte", tx_data, exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [3:0] nn, input logic [3:0] a, input logic [3:0] b,
                              input logic [3:0] c, input logic [3:0] d, input logic s);
        logic [3:0] dg[4];
        int cnt;
        dg  = '{a, b, c, d};
        cnt = (nn > 4) ? 4 : int'(nn);
        if (s) exp_q.push_back(8'h2D);
        if (cnt == 0) exp_q.push_back(8'h30);
        else for (int i = 4 - cnt; i < 4; i++)
            exp_q.push_back((dg[i] > 4'd9) ? 8'h3F : 8'h30 + {4'h0, dg[i]});
`ifdef UART_TX_TERM_EN
        exp_q.push_back(8'h0D);
`endif
    endtask

    task automatic fire(input logic [3:0] nn, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [3:0] d, input logic s,
                        input bit expect_sent);
        n = nn; num1 = a; num2 = b; num3 = c; num4 = d; sign = s;
        start = 1'b1;
        if (expect_sent) push_frame(nn, a, b, c, d, s);
        tick();
        start = 1'b0;
        n = 4'h0; num1 = 4'hF; num2 = 4'hF; num3 = 4'hF; num4 = 4'hF; sign = 1'b0;
    endtask

    task automatic drain(input string tag);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            if (exp_q.size() == 0 && tx_valid === 1'b0 && busy === 1'b0) done = 1'b1;
            else tick();
        end
        check({tag, "_drained"}, {7'b0, done}, 8'h01);
    endtask

    initial begin
        int gap, low_run;
        bit seen_hi, done;

        reset = 1'b1; start = 1'b0; tx_ready = 1'b1; sign = 1'b0;
        n = 4'h0; num1 = 4'h0; num2 = 4'h0; num3 = 4'h0; num4 = 4'h0;
        tick(); tick();
        check("rst_tx_valid", {7'b0, tx_valid}, 8'h00);
        check("rst_tx_data",  tx_data, 8'h00);
        check("rst_busy",     {7'b0, busy}, 8'h00);
        check("rst_overrun",  {7'b0, overrun}, 8'h00);
        reset = 1'b0;
        tick();

        // Plain frame, one byte per cycle, busy drops right after the last accept
        fire(4'd3, 4'd0, 4'd1, 4'd2, 4'd5, 1'b0, 1'b1);
        check("t1_valid_latency", {7'b0, tx_valid}, 8'h01);
        check("t1_first_byte",    tx_data, 8'h31);
        check("t1_busy_rise",     {7'b0, busy}, 8'h01);
        tick(); tick();
`ifdef UART_TX_TERM_EN
        tick();
`endif
        check("t1_busy_last", {7'b0, busy}, 8'h01);
        tick();
        check("t1_busy_fall",  {7'b0, busy}, 8'h00);
        check("t1_valid_fall", {7'b0, tx_valid}, 8'h00);
        drain("t1");

        // Stalled sign byte must hold
        tx_ready = 1'b0;
        fire(4'd2, 4'd9, 4'd9, 4'd4, 4'd7, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_data",  tx_data, 8'h2D);
            check("t2_hold_valid", {7'b0, tx_valid}, 8'h01);
            tick();
        end
        tx_ready = 1'b1;
        drain("t2");

        // Boundaries: empty count, clamped count, non-BCD digit
        fire(4'd0, 4'd7, 4'd7, 4'd7, 4'd7, 1'b0, 1'b1);
        check("t3_zero_byte", tx_data, 8'h30);
        drain("t3a");
        fire(4'd7, 4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 1'b1);
        check("t3_clamp_first", tx_data, 8'h31);
        drain("t3b");
        fire(4'd4, 4'd9, 4'hB, 4'd0, 4'd1, 1'b1, 1'b1);
        drain("t3c");
        fire(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1);
        drain("t3d");

        // Queue one, drop one while stalled
        tx_ready = 1'b0;
        fire(4'd1, 4'd0, 4'd0, 4'd0, 4'd5, 1'b0, 1'b1);
        fire(4'd2, 4'd0, 4'd0, 4'd6, 4'd7, 1'b0, 1'b1);
        check("t4_no_overrun_yet", {7'b0, overrun}, 8'h00);
        fire(4'd1, 4'd0, 4'd0, 4'd0, 4'd8, 1'b0, 1'b0);
        check("t4_overrun_pulse", {7'b0, overrun}, 8'h01);
        check("t4_held_first", tx_data, 8'h35);
        tick();
        check("t4_overrun_one_cycle", {7'b0, overrun}, 8'h00);
        tx_ready = 1'b1;
        gap = -1; low_run = 0; seen_hi = 1'b0; done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (tx_valid === 1'b1) begin
                if (seen_hi && low_run > 0) gap = low_run;
                seen_hi = 1'b1;
                low_run = 0;
            end else if (seen_hi) begin
                low_run++;
            end
            if (exp_q.size() == 0 && busy === 1'b0) done = 1'b1;
            else tick();
        end
        check("t4_gap_cycles", 8'(gap), 8'd1);
        check("t4_overrun_after", {7'b0, overrun}, 8'h00);
        drain("t4");

        // Start coincident with the final accept goes to the pending slot
        fire(4'd1, 4'd0, 4'd0, 4'd0, 4'd2, 1'b0, 1'b1);
`ifdef UART_TX_TERM_EN
        tick();
`endif
        check("t5_valid_last", {7'b0, tx_valid}, 8'h01);
        fire(4'd1, 4'd0, 4'd0, 4'd0, 4'd3, 1'b0, 1'b1);
        check("t5_gap_valid",  {7'b0, tx_valid}, 8'h00);
        check("t5_gap_busy",   {7'b0, busy}, 8'h01);
        check("t5_no_overrun", {7'b0, overrun}, 8'h00);
        tick();
        check("t5_next_valid", {7'b0, tx_valid}, 8'h01);
        check("t5_next_byte",  tx_data, 8'h33);
        drain("t5");

        // Reset mid-digit with pending full aborts everything
        tx_ready = 1'b0;
        fire(4'd4, 4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 1'b1);
        fire(4'd2, 4'd0, 4'd0, 4'd5, 4'd6, 1'b0, 1'b1);
        tx_ready = 1'b1;
        tick();
        check("t6_mid_digit", tx_data, 8'h32);
        reset = 1'b1;
        tick();
        exp_q.delete();
        reset = 1'b0;
        check("t6_valid_after_reset", {7'b0, tx_valid}, 8'h00);
        check("t6_busy_after_reset",  {7'b0, busy}, 8'h00);
        for (int i = 0; i < 10; i++) tick();
        check("t6_still_idle_valid", {7'b0, tx_valid}, 8'h00);
        check("t6_still_idle_busy",  {7'b0, busy}, 8'h00);

        check("sb_empty", 8'(exp_q.size()), 8'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
